// File: rtl/btb_if.sv
// Fetch/execute-side bus of the branch target buffer: IF lookup, EX training,
// flush and statistics.
interface btb_if #(
  parameter int PC_W   = 32,
  parameter int STAT_W = 32
);
  logic [PC_W-1:0]   lu_pc;
  logic              lu_hit;
  logic              lu_taken;
  logic [PC_W-1:0]   lu_next_pc;
  logic              upd_en;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [PC_W-1:0]   upd_target;
  logic              upd_uncond;
  logic              upd_mispred;
  logic              flush;
  logic [STAT_W-1:0] stat_br;
  logic [STAT_W-1:0] stat_misp;

  modport master (
    output lu_pc, upd_en, upd_pc, upd_taken, upd_target, upd_uncond, upd_mispred, flush,
    input  lu_hit, lu_taken, lu_next_pc, stat_br, stat_misp
  );
  modport slave (
    input  lu_pc, upd_en, upd_pc, upd_taken, upd_target, upd_uncond, upd_mispred, flush,
    output lu_hit, lu_taken, lu_next_pc, stat_br, stat_misp
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped flop-based BTB with saturating direction counters, 0-cycle
// lookup, EX-driven training, flush and saturating branch/mispredict stats.
module btb_entry #(
  parameter int TAG_W = 26,
  parameter int PC_W  = 32,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             flush,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  logic [CTR_W-1:0] wr_ctr,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [PC_W-1:0]  target,
  output logic [CTR_W-1:0] ctr
);
  // Flush beats a same-cycle write so nothing survives a context switch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= '0;
    end else if (flush) begin
      valid  <= 1'b0;
    end else if (wr) begin
      valid  <= 1'b1;
      tag    <= wr_tag;
      target <= wr_target;
      ctr    <= wr_ctr;
    end
  end
endmodule

module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic  clk,
  input  logic  rst,
  btb_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag;
  logic [ENTRIES-1:0][PC_W-1:0]   target;
  logic [ENTRIES-1:0][CTR_W-1:0]  ctr;

  logic [IDX_W-1:0]   lu_idx, u_idx;
  logic [TAG_W-1:0]   lu_tag, u_tag;
  logic               u_hit, u_tk, wr;
  logic [CTR_W-1:0]   cur_ctr, new_ctr;
  logic [PC_W-1:0]    new_target;
  logic [ENTRIES-1:0] wr_sel;
  logic [STAT_W-1:0]  stat_br, stat_misp;

  // Lookup reads registered state only, so same-cycle updates are invisible.
  assign lu_idx         = bus.lu_pc[2 +: IDX_W];
  assign lu_tag         = bus.lu_pc[PC_W-1 : 2+IDX_W];
  assign bus.lu_hit     = valid[lu_idx] && (tag[lu_idx] == lu_tag);
  assign bus.lu_taken   = bus.lu_hit && ctr[lu_idx][CTR_W-1];
  assign bus.lu_next_pc = bus.lu_taken ? target[lu_idx] : bus.lu_pc + PC_W'(4);

  assign u_idx   = bus.upd_pc[2 +: IDX_W];
  assign u_tag   = bus.upd_pc[PC_W-1 : 2+IDX_W];
  assign u_hit   = valid[u_idx] && (tag[u_idx] == u_tag);
  assign u_tk    = bus.upd_taken | bus.upd_uncond;  // illegal uncond/not-taken treated as taken
  assign cur_ctr = ctr[u_idx];
  assign wr      = bus.upd_en && (u_hit || u_tk);
  assign wr_sel  = wr ? (ENTRIES'(1) << u_idx) : '0;

  always_comb begin
    new_ctr    = cur_ctr;
    new_target = bus.upd_target;
    if (!u_hit)               new_ctr = bus.upd_uncond ? CTR_MAX : CTR_WEAK;
    else if (bus.upd_uncond)  new_ctr = CTR_MAX;
    else if (u_tk)            new_ctr = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + CTR_W'(1);
    else begin
      new_ctr    = (cur_ctr == '0) ? cur_ctr : cur_ctr - CTR_W'(1);
      new_target = target[u_idx];
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    btb_entry #(.TAG_W(TAG_W), .PC_W(PC_W), .CTR_W(CTR_W)) u_ent (
      .clk       (clk),
      .rst       (rst),
      .wr        (wr_sel[g]),
      .flush     (bus.flush),
      .wr_tag    (u_tag),
      .wr_target (new_target),
      .wr_ctr    (new_ctr),
      .valid     (valid[g]),
      .tag       (tag[g]),
      .target    (target[g]),
      .ctr       (ctr[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br   <= '0;
      stat_misp <= '0;
    end else begin
      if (bus.upd_en && stat_br != '1)                     stat_br   <= stat_br + STAT_W'(1);
      if (bus.upd_en && bus.upd_mispred && stat_misp != '1) stat_misp <= stat_misp + STAT_W'(1);
    end
  end

  assign bus.stat_br   = stat_br;
  assign bus.stat_misp = stat_misp;

  a_uncond_taken: assert property (@(posedge clk) disable iff (!rst)
    bus.upd_en |-> !(bus.upd_uncond && !bus.upd_taken));
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer (ENTRIES=16, CTR_W=2, STAT_W=4).
module tb_branch_target_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  btb_if #(.PC_W(32), .STAT_W(4)) bus ();

  branch_target_buffer #(.ENTRIES(16), .PC_W(32), .CTR_W(2), .STAT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        ue;
    logic [31:0] upc;
    logic        tk;
    logic [31:0] tgt;
    logic        unc;
    logic        mp;
    logic        fl;
    logic [31:0] lpc;
    logic        eh;
    logic        et;
    logic [31:0] en;
  } vec_t;

  vec_t tv[$];
  int   nvec = 0;
  int   nerr = 0;
  int   exp_br = 0, exp_misp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ue, input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                     input logic unc, input logic mp, input logic fl, input logic [31:0] lpc,
                     input logic eh, input logic et, input logic [31:0] en);
    vec_t v;
    v.ue = ue; v.upc = upc; v.tk = tk; v.tgt = tgt; v.unc = unc; v.mp = mp; v.fl = fl;
    v.lpc = lpc; v.eh = eh; v.et = et; v.en = en;
    tv.push_back(v);
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc, input logic eh, input logic et,
                        input logic [31:0] en);
    bus.lu_pc = pc;
    #1;
    chk({nm, ".hit"},  {31'b0, bus.lu_hit},   {31'b0, eh});
    chk({nm, ".tk"},   {31'b0, bus.lu_taken}, {31'b0, et});
    chk({nm, ".next"}, bus.lu_next_pc,        en);
  endtask

  task automatic idle();
    bus.upd_en = 0; bus.upd_pc = '0; bus.upd_taken = 0; bus.upd_target = '0;
    bus.upd_uncond = 0; bus.upd_mispred = 0; bus.flush = 0;
  endtask

  task automatic stat_chk(input string nm);
    chk({nm, ".br"},   {28'b0, bus.stat_br},   exp_br);
    chk({nm, ".misp"}, {28'b0, bus.stat_misp}, exp_misp);
  endtask

  initial begin
    //  ue upc         tk tgt          unc mp fl lpc          eh et next
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h100,     0, 0, 32'h104);
    add(1, 32'h100,    1, 32'h80,      0,  0, 0, 32'h100,     0, 0, 32'h104); // same-cycle: old view
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h100,     1, 1, 32'h80);
    add(1, 32'h100,    0, 32'h0,       0,  0, 0, 32'h100,     1, 1, 32'h80);  // ctr 2->1
    add(1, 32'h100,    0, 32'h0,       0,  0, 0, 32'h100,     1, 0, 32'h104); // ctr 1->0
    add(1, 32'h100,    0, 32'h0,       0,  0, 0, 32'h100,     1, 0, 32'h104); // stays 0
    add(1, 32'h100,    1, 32'h90,      0,  0, 0, 32'h100,     1, 0, 32'h104); // 0->1
    add(1, 32'h100,    1, 32'h90,      0,  0, 0, 32'h100,     1, 0, 32'h104); // 1->2
    add(1, 32'h100,    1, 32'h90,      0,  0, 0, 32'h100,     1, 1, 32'h90);  // 2->3
    add(1, 32'h100,    1, 32'h90,      0,  0, 0, 32'h100,     1, 1, 32'h90);  // sat 3
    add(1, 32'h100,    0, 32'h0,       0,  0, 0, 32'h100,     1, 1, 32'h90);  // 3->2
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h100,     1, 1, 32'h90);
    add(1, 32'h140,    1, 32'h200,     0,  1, 0, 32'h140,     0, 0, 32'h144); // alias evicts 0x100
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h100,     0, 0, 32'h104);
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h140,     1, 1, 32'h200);
    add(1, 32'h104,    1, 32'h300,     1,  1, 0, 32'h104,     0, 0, 32'h108); // uncond alloc ctr=3
    add(1, 32'h104,    0, 32'h0,       0,  0, 0, 32'h104,     1, 1, 32'h300); // 3->2
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h104,     1, 1, 32'h300);
    add(1, 32'h108,    0, 32'h0,       0,  0, 0, 32'h108,     0, 0, 32'h10C); // miss nt: no alloc
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h108,     0, 0, 32'h10C);
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'hFFFFFFFC, 0, 0, 32'h0);  // pc+4 wraps
    add(1, 32'h104,    1, 32'h400,     1,  0, 0, 32'h104,     1, 1, 32'h300); // uncond hit retarget
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h104,     1, 1, 32'h400);
    add(1, 32'h180,    1, 32'h500,     0,  1, 1, 32'h140,     1, 1, 32'h200); // flush + update
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h140,     0, 0, 32'h144);
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h180,     0, 0, 32'h184);
    add(0, 32'h0,      0, 32'h0,       0,  0, 0, 32'h104,     0, 0, 32'h108);

    idle();
    bus.lu_pc = 32'h100;
    repeat (2) @(negedge clk);
    lookup("rst_hold", 32'h100, 0, 0, 32'h104);
    stat_chk("rst_hold");
    rst = 1'b1;
    @(negedge clk);
    lookup("post_rst", 32'h100, 0, 0, 32'h104);
    stat_chk("post_rst");

    foreach (tv[i]) begin
      @(negedge clk);
      bus.upd_en = tv[i].ue; bus.upd_pc = tv[i].upc; bus.upd_taken = tv[i].tk;
      bus.upd_target = tv[i].tgt; bus.upd_uncond = tv[i].unc; bus.upd_mispred = tv[i].mp;
      bus.flush = tv[i].fl;
      lookup($sformatf("v%0d", i), tv[i].lpc, tv[i].eh, tv[i].et, tv[i].en);
      stat_chk($sformatf("v%0d", i));
      @(posedge clk);
      if (tv[i].ue) begin
        if (exp_br < 15) exp_br++;
        if (tv[i].mp && exp_misp < 15) exp_misp++;
      end
    end

    // Drive stats into saturation with mispredicted not-taken misses.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idle();
      bus.upd_en = 1; bus.upd_pc = 32'h108; bus.upd_mispred = 1;
      @(posedge clk);
      if (exp_br < 15) exp_br++;
      if (exp_misp < 15) exp_misp++;
    end
    @(negedge clk);
    idle();
    bus.upd_mispred = 1;  // ignored without upd_en
    #1;
    chk("sat.br",   {28'b0, bus.stat_br},   32'd15);
    chk("sat.misp", {28'b0, bus.stat_misp}, 32'd15);
    @(posedge clk);
    @(negedge clk);
    chk("sat.hold", {28'b0, bus.stat_misp}, 32'd15);

    // Train an entry, then reset in the middle of another update.
    idle();
    bus.upd_en = 1; bus.upd_pc = 32'h104; bus.upd_taken = 1; bus.upd_target = 32'h600;
    @(negedge clk);
    idle();
    lookup("pre_rst", 32'h104, 1, 1, 32'h600);
    bus.upd_en = 1; bus.upd_pc = 32'h200; bus.upd_taken = 1; bus.upd_target = 32'h700;
    rst = 1'b0;
    #1;
    exp_br = 0; exp_misp = 0;
    lookup("mid_rst", 32'h104, 0, 0, 32'h108);
    stat_chk("mid_rst");
    @(negedge clk);
    idle();
    rst = 1'b1;
    lookup("after_rst_a", 32'h200, 0, 0, 32'h204);
    lookup("after_rst_b", 32'h104, 0, 0, 32'h108);
    stat_chk("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
